phase_timing: RTL and testbench



---
 rtl/phase_timing.sv | 164 ++++++++++++++++
 tb/tb_phase_timing.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timing.sv
// Instruction-cycle timing generator: tracks the eight MCS-4 subcycles from the
// clockgen two-phase clocks, drives SYNC, phase-edge strobes, a cycle counter and an error flag.
module phase_timing #(
    parameter int CNT_W = 16
) (
    input  logic             sysclk,
    input  logic             poc,
    input  logic             clk1,
    input  logic             clk2,
    output logic             phi1_rise,
    output logic             phi1_fall,
    output logic             phi2_rise,
    output logic             phi2_fall,
    output logic [2:0]       subcycle,
    output logic [7:0]       phase,
    output logic             sync,
    output logic             started,
    output logic [CNT_W-1:0] cycle_count,
    output logic             phase_err
);

    typedef enum logic [2:0] {
        SC_A1 = 3'd0,
        SC_A2 = 3'd1,
        SC_A3 = 3'd2,
        SC_M1 = 3'd3,
        SC_M2 = 3'd4,
        SC_X1 = 3'd5,
        SC_X2 = 3'd6,
        SC_X3 = 3'd7
    } subcycle_t;

    // Bit 0 tracks clk1, bit 1 tracks clk2.
    logic [1:0] clk_now;
    logic [1:0] clk_q_reg;
    logic [1:0] rise_now;
    logic [1:0] fall_now;
    logic [1:0] rise_reg;
    logic [1:0] fall_reg;

    assign clk_now = {clk2, clk1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            assign rise_now[gi] = clk_now[gi] & ~clk_q_reg[gi];
            assign fall_now[gi] = ~clk_now[gi] & clk_q_reg[gi];
        end
    endgenerate

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            clk_q_reg <= 2'b00;
            rise_reg  <= 2'b00;
            fall_reg  <= 2'b00;
        end else begin
            clk_q_reg <= clk_now;
            rise_reg  <= rise_now;
            fall_reg  <= fall_now;
        end
    end

    // Internal sequencer parks in X3 during reset so the first clk1 rise lands on A1.
    subcycle_t sub_state_reg;
    subcycle_t sub_state_next;

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            sub_state_reg <= SC_X3;
        end else begin
            sub_state_reg <= sub_state_next;
        end
    end

    always_comb begin
        sub_state_next = sub_state_reg;
        if (rise_now[0]) begin
            case (sub_state_reg)
                SC_A1:   sub_state_next = SC_A2;
                SC_A2:   sub_state_next = SC_A3;
                SC_A3:   sub_state_next = SC_M1;
                SC_M1:   sub_state_next = SC_M2;
                SC_M2:   sub_state_next = SC_X1;
                SC_X1:   sub_state_next = SC_X2;
                SC_X2:   sub_state_next = SC_X3;
                SC_X3:   sub_state_next = SC_A1;
                default: sub_state_next = SC_A1;
            endcase
        end
    end

    logic             started_reg;
    logic             started_next;
    logic [2:0]       sub_idx_next;
    logic [2:0]       subcycle_reg;
    logic [2:0]       subcycle_next;
    logic [7:0]       phase_reg;
    logic [7:0]       phase_next;
    logic             sync_reg;
    logic             sync_next;
    logic [CNT_W-1:0] cycle_count_reg;
    logic [CNT_W-1:0] cycle_count_next;
    logic             c2_fall_seen_reg;
    logic             c2_fall_seen_next;
    logic             phase_err_reg;
    logic             phase_err_next;
    logic             overlap_err;
    logic             missing_phi2_err;

    assign sub_idx_next = sub_state_next;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_phase
            assign phase_next[gi] = started_next && (sub_idx_next == 3'(gi));
        end
    endgenerate

    // A clk2 fall sampled together with the clk1 rise still satisfies the ordering check.
    always_comb begin
        started_next      = started_reg | rise_now[0];
        subcycle_next     = started_next ? sub_idx_next : 3'd0;
        sync_next         = started_next && (sub_state_next == SC_X3);
        cycle_count_next  = cycle_count_reg;
        if (rise_now[0] && (sub_state_next == SC_A1)) begin
            cycle_count_next = cycle_count_reg + CNT_W'(1);
        end
        c2_fall_seen_next = rise_now[0] ? 1'b0 : (c2_fall_seen_reg | fall_now[1]);
        overlap_err       = clk1 & clk2;
        missing_phi2_err  = started_reg & rise_now[0] & ~(c2_fall_seen_reg | fall_now[1]);
        phase_err_next    = phase_err_reg | overlap_err | missing_phi2_err;
    end

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            started_reg      <= 1'b0;
            subcycle_reg     <= 3'd0;
            phase_reg        <= 8'd0;
            sync_reg         <= 1'b0;
            cycle_count_reg  <= '0;
            c2_fall_seen_reg <= 1'b0;
            phase_err_reg    <= 1'b0;
        end else begin
            started_reg      <= started_next;
            subcycle_reg     <= subcycle_next;
            phase_reg        <= phase_next;
            sync_reg         <= sync_next;
            cycle_count_reg  <= cycle_count_next;
            c2_fall_seen_reg <= c2_fall_seen_next;
            phase_err_reg    <= phase_err_next;
        end
    end

    assign phi1_rise   = rise_reg[0];
    assign phi1_fall   = fall_reg[0];
    assign phi2_rise   = rise_reg[1];
    assign phi2_fall   = fall_reg[1];
    assign subcycle    = subcycle_reg;
    assign phase       = phase_reg;
    assign sync        = sync_reg;
    assign started     = started_reg;
    assign cycle_count = cycle_count_reg;
    assign phase_err   = phase_err_reg;

endmodule

// File: tb/tb_phase_timing.sv
// Directed bench for phase_timing: drives a clockgen-shaped two-phase sequence
// (20 high / 20 gap / 20 high / 10 gap) and checks timing, counting and error flagging.
module tb_phase_timing;

    logic        sysclk = 1'b0;
    logic        poc    = 1'b1;
    logic        clk1   = 1'b0;
    logic        clk2   = 1'b0;

    logic        phi1_rise, phi1_fall, phi2_rise, phi2_fall;
    logic [2:0]  subcycle;
    logic [7:0]  phase;
    logic        sync, started, phase_err;
    logic [15:0] cycle_count;

    logic        w_phi1_rise, w_phi1_fall, w_phi2_rise, w_phi2_fall;
    logic [2:0]  w_subcycle;
    logic [7:0]  w_phase;
    logic        w_sync, w_started, w_phase_err;
    logic [2:0]  w_cycle_count;

    phase_timing #(.CNT_W(16)) dut (
        .sysclk(sysclk), .poc(poc), .clk1(clk1), .clk2(clk2),
        .phi1_rise(phi1_rise), .phi1_fall(phi1_fall),
        .phi2_rise(phi2_rise), .phi2_fall(phi2_fall),
        .subcycle(subcycle), .phase(phase), .sync(sync), .started(started),
        .cycle_count(cycle_count), .phase_err(phase_err)
    );

    phase_timing #(.CNT_W(3)) dut_wrap (
        .sysclk(sysclk), .poc(poc), .clk1(clk1), .clk2(clk2),
        .phi1_rise(w_phi1_rise), .phi1_fall(w_phi1_fall),
        .phi2_rise(w_phi2_rise), .phi2_fall(w_phi2_fall),
        .subcycle(w_subcycle), .phase(w_phase), .sync(w_sync), .started(w_started),
        .cycle_count(w_cycle_count), .phase_err(w_phase_err)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;
    int nsub  = 0;

    // Observations taken right after the edge that samples a subcycle's clk1 rise.
    logic [2:0]  r_sub;
    logic [7:0]  r_phase;
    logic        r_sync, r_started, r_err, r_p1r, r_p2f;
    logic [15:0] r_cc;
    logic [2:0]  r_cc3;
    logic        e_pre, e_post;
    int          n_p1r, n_p1f, n_p2r, n_p2f, n_sync;

    function automatic logic [33:0] all_outputs();
        return {phi1_rise, phi1_fall, phi2_rise, phi2_fall, subcycle, phase,
                sync, started, cycle_count, phase_err};
    endfunction

    task automatic step(input logic c1, input logic c2);
        clk1 = c1;
        clk2 = c2;
        @(posedge sysclk);
        #1;
        n_p1r  += int'(phi1_rise);
        n_p1f  += int'(phi1_fall);
        n_p2r  += int'(phi2_rise);
        n_p2f  += int'(phi2_fall);
        n_sync += int'(sync);
    endtask

    // mode 0 normal, 1 no clk2 pulse, 2 one-cycle overlap, 3 clk2 held to next rise, 4 stop mid-subcycle
    task automatic run_sub(input int mode);
        logic c1, c2;
        int   len;
        n_p1r = 0; n_p1f = 0; n_p2r = 0; n_p2f = 0; n_sync = 0;
        len = (mode == 4) ? 30 : 70;
        nsub++;
        for (int i = 0; i < len; i++) begin
            c1 = (i < 20);
            c2 = (i >= 40 && i < 60);
            if (mode == 1) c2 = 1'b0;
            if (mode == 3) c2 = (i >= 40);
            if (mode == 2 && i == 10) c2 = 1'b1;
            step(c1, c2);
            if (i == 0) begin
                r_sub = subcycle; r_phase = phase; r_sync = sync; r_started = started;
                r_err = phase_err; r_p1r = phi1_rise; r_p2f = phi2_fall;
                r_cc = cycle_count; r_cc3 = w_cycle_count;
            end
            if (i == 9)  e_pre  = phase_err;
            if (i == 10) e_post = phase_err;
        end
    endtask

    task automatic test_reset();
        logic [33:0] obs;
        poc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(logic'(i % 2), 1'b0);
            obs = all_outputs();
            total++;
            if (obs !== 34'd0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got %h want 0", i, obs);
            end
        end
        step(1'b0, 1'b0);
        poc = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        obs = all_outputs();
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %h want 0", obs);
        end
        nsub = 0;
        run_sub(0);
        total++;
        if (r_sub !== 3'd0 || r_phase !== 8'h01 || r_started !== 1'b1 || r_cc !== 16'd1 ||
            r_p1r !== 1'b1 || r_sync !== 1'b0 || r_err !== 1'b0) begin
            bad++;
            $display("FAIL first_rise: sub=%0d phase=%h started=%b cc=%0d p1r=%b sync=%b err=%b want 0 01 1 1 1 0 0",
                     r_sub, r_phase, r_started, r_cc, r_p1r, r_sync, r_err);
        end
        total++;
        if (n_p1r != 1 || n_p1f != 1 || n_p2r != 1 || n_p2f != 1 || n_sync != 0) begin
            bad++;
            $display("FAIL first_strobes: p1r=%0d p1f=%0d p2r=%0d p2f=%0d sync=%0d want 1 1 1 1 0",
                     n_p1r, n_p1f, n_p2r, n_p2f, n_sync);
        end
        $display("reset: first A1 sub=%0d phase=%h cc=%0d", r_sub, r_phase, r_cc);
    endtask

    // Runs through the 9th A1 so the 3-bit counter instance wraps 7 -> 0 -> 1.
    task automatic test_steady();
        int         idx, a1s;
        logic [7:0] exp_ph;
        logic [2:0] exp3;
        while (nsub < 65) begin
            run_sub(0);
            idx    = (nsub - 1) % 8;
            a1s    = (nsub + 7) / 8;
            exp_ph = 8'(1) << idx;
            exp3   = 3'(a1s % 8);
            total++;
            if (r_sub !== 3'(idx) || r_phase !== exp_ph || r_sync !== (idx == 7)) begin
                bad++;
                $display("FAIL seq sub#%0d: sub=%0d phase=%h sync=%b want %0d %h %b",
                         nsub, r_sub, r_phase, r_sync, idx, exp_ph, idx == 7);
            end
            total++;
            if (n_sync != ((idx == 7) ? 70 : 0)) begin
                bad++;
                $display("FAIL sync_width sub#%0d: got %0d want %0d", nsub, n_sync, (idx == 7) ? 70 : 0);
            end
            total++;
            if (n_p1r != 1 || n_p1f != 1 || n_p2r != 1 || n_p2f != 1) begin
                bad++;
                $display("FAIL strobes sub#%0d: p1r=%0d p1f=%0d p2r=%0d p2f=%0d want 1 each",
                         nsub, n_p1r, n_p1f, n_p2r, n_p2f);
            end
            total++;
            if (r_cc !== 16'(a1s) || r_cc3 !== exp3) begin
                bad++;
                $display("FAIL count sub#%0d: cc=%0d cc3=%0d want %0d %0d", nsub, r_cc, r_cc3, a1s, exp3);
            end
            if (idx == 0) $display("A1 entry %0d: cc=%0d cc3=%0d", a1s, r_cc, r_cc3);
        end
        total++;
        if (phase_err !== 1'b0) begin
            bad++;
            $display("FAIL steady_no_err: got %b want 0", phase_err);
        end
    endtask

    task automatic test_overlap();
        int idx;
        run_sub(2);
        total++;
        if (e_pre !== 1'b0 || e_post !== 1'b1) begin
            bad++;
            $display("FAIL overlap_set: before=%b after=%b want 0 1", e_pre, e_post);
        end
        for (int k = 0; k < 3; k++) begin
            run_sub(0);
            idx = (nsub - 1) % 8;
            total++;
            if (r_err !== 1'b1 || r_sub !== 3'(idx) || phase_err !== 1'b1) begin
                bad++;
                $display("FAIL overlap_sticky sub#%0d: err=%b sub=%0d want 1 %0d", nsub, r_err, r_sub, idx);
            end
        end
        $display("overlap: phase_err=%b sub=%0d", phase_err, subcycle);
    endtask

    task automatic test_mid_reset();
        logic [33:0] obs;
        while (nsub % 8 != 4) run_sub(0);
        run_sub(4);
        total++;
        if (r_sub !== 3'd4 || subcycle !== 3'd4) begin
            bad++;
            $display("FAIL reach_m2: got %0d want 4", r_sub);
        end
        #2;
        poc = 1'b1;
        #1;
        obs = all_outputs();
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL async_clear: got %h want 0", obs);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        poc  = 1'b0;
        nsub = 0;
        run_sub(0);
        total++;
        if (r_sub !== 3'd0 || r_cc !== 16'd1 || r_phase !== 8'h01 || r_started !== 1'b1 || r_err !== 1'b0) begin
            bad++;
            $display("FAIL restart: sub=%0d cc=%0d phase=%h started=%b err=%b want 0 1 01 1 0",
                     r_sub, r_cc, r_phase, r_started, r_err);
        end
        $display("mid reset: restart sub=%0d cc=%0d", r_sub, r_cc);
    endtask

    task automatic test_simultaneous();
        run_sub(0);
        run_sub(3);
        run_sub(0);
        total++;
        if (r_p1r !== 1'b1 || r_p2f !== 1'b1 || r_err !== 1'b0 || r_sub !== 3'((nsub - 1) % 8)) begin
            bad++;
            $display("FAIL simultaneous: p1r=%b p2f=%b err=%b sub=%0d want 1 1 0 %0d",
                     r_p1r, r_p2f, r_err, r_sub, (nsub - 1) % 8);
        end
        $display("simultaneous edges: p1r=%b p2f=%b err=%b", r_p1r, r_p2f, r_err);
    endtask

    task automatic test_missing_phase2();
        logic [2:0] prev;
        run_sub(1);
        total++;
        if (r_err !== 1'b0) begin
            bad++;
            $display("FAIL missing_pre: err=%b want 0", r_err);
        end
        prev = r_sub;
        run_sub(0);
        total++;
        if (r_err !== 1'b1 || r_sub !== prev + 3'd1) begin
            bad++;
            $display("FAIL missing_phase2: err=%b sub=%0d want 1 %0d", r_err, r_sub, prev + 3'd1);
        end
        $display("missing phase-2: err=%b sub=%0d", r_err, r_sub);
    endtask

    initial begin
        test_reset();
        test_steady();
        test_overlap();
        test_mid_reset();
        test_simultaneous();
        test_missing_phase2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
